// File: rtl/debug_dump_sequencer_if.sv
// Bundles the debug dump controller's start/snapshot, register/memory debug read
// ports and UART TX handshake into one interface.
interface debug_dump_sequencer_if #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_REG      = 5,
    parameter int unsigned NB_MEM_ADDR = 7,
    parameter int unsigned NB_PC       = 32
) ();
    logic                   start;
    logic [NB_PC-1:0]       pc;
    logic [NB_PC-1:0]       cycles;
    logic [NB_REG-1:0]      reg_addr;
    logic                   reg_rd;
    logic [NB_DATA-1:0]     reg_data;
    logic [NB_MEM_ADDR-1:0] mem_addr;
    logic                   mem_rd;
    logic [NB_DATA-1:0]     mem_data;
    logic                   mem_dirty;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_done;
    logic                   busy;
    logic                   done;

    // Sequencer side.
    modport slave (
        input  start, pc, cycles, reg_data, mem_data, mem_dirty, tx_done,
        output reg_addr, reg_rd, mem_addr, mem_rd, tx_data, tx_start, busy, done
    );

    // Debug unit / register bank / memory / UART side.
    modport master (
        output start, pc, cycles, reg_data, mem_data, mem_dirty, tx_done,
        input  reg_addr, reg_rd, mem_addr, mem_rd, tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Post-halt dump controller: serializes PC, cycle count, register bank and dirty
// data-memory words MSB first into the UART TX, terminated by a 0xFF marker.
module debug_dump_sequencer #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_REG      = 5,
    parameter int unsigned NB_MEM_ADDR = 7,
    parameter int unsigned NB_PC       = 32
) (
    input logic                     i_clock,
    input logic                     i_reset,
    debug_dump_sequencer_if.slave   dbg
);

    localparam int unsigned NbField = (NB_PC > NB_DATA) ? NB_PC : NB_DATA;
    // One spare byte on top so a dirty word loads as {addr, data} in one shot.
    localparam int unsigned NbSh    = NbField + 8;
    localparam int unsigned NbCnt   = $clog2(NbField / 8 + 2);

    localparam logic [NB_REG-1:0]      LastReg = '1;
    localparam logic [NB_MEM_ADDR-1:0] LastMem = '1;

    typedef enum logic [3:0] {
        StIdle,
        StSend,
        StTxWait,
        StCyc,
        StRegReq,
        StRegWait,
        StMemReq,
        StMemWait,
        StMark,
        StFin
    } state_e;

    state_e                 state_q, state_d;
    state_e                 ret_q, ret_d;
    logic [NbSh-1:0]        shreg_q, shreg_d;
    logic [NbCnt-1:0]       cnt_q, cnt_d;
    logic [NB_PC-1:0]       cyc_q, cyc_d;
    logic [NB_REG-1:0]      reg_idx_q, reg_idx_d;
    logic [NB_REG-1:0]      reg_addr_q, reg_addr_d;
    logic [NB_MEM_ADDR-1:0] mem_idx_q, mem_idx_d;
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
    state_e                 mem_next;

    logic reg_rd, mem_rd, tx_start, done;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            ret_q      <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            cyc_q      <= '0;
            reg_idx_q  <= '0;
            reg_addr_q <= '0;
            mem_idx_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            reg_idx_q  <= reg_idx_d;
            reg_addr_q <= reg_addr_d;
            mem_idx_q  <= mem_idx_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        reg_idx_d  = reg_idx_q;
        reg_addr_d = reg_addr_q;
        mem_idx_d  = mem_idx_q;
        mem_addr_d = mem_addr_q;
        reg_rd     = 1'b0;
        mem_rd     = 1'b0;
        tx_start   = 1'b0;
        done       = 1'b0;
        mem_next   = (mem_idx_q == LastMem) ? StMark : StMemReq;

        unique case (state_q)
            StIdle: begin
                if (dbg.start) begin
                    shreg_d   = NbSh'(dbg.pc) << (NbSh - NB_PC);
                    cnt_d     = NbCnt'(NB_PC / 8);
                    cyc_d     = dbg.cycles;
                    reg_idx_d = '0;
                    mem_idx_d = '0;
                    ret_d     = StCyc;
                    state_d   = StSend;
                end
            end
            StSend: begin
                tx_start = 1'b1;
                state_d  = StTxWait;
            end
            StTxWait: begin
                if (dbg.tx_done) begin
                    shreg_d = shreg_q << 8;
                    cnt_d   = cnt_q - NbCnt'(1);
                    state_d = (cnt_q == NbCnt'(1)) ? ret_q : StSend;
                end
            end
            StCyc: begin
                shreg_d = NbSh'(cyc_q) << (NbSh - NB_PC);
                cnt_d   = NbCnt'(NB_PC / 8);
                ret_d   = StRegReq;
                state_d = StSend;
            end
            StRegReq: begin
                reg_rd     = 1'b1;
                reg_addr_d = reg_idx_q;
                state_d    = StRegWait;
            end
            StRegWait: begin
                shreg_d   = NbSh'(dbg.reg_data) << (NbSh - NB_DATA);
                cnt_d     = NbCnt'(NB_DATA / 8);
                ret_d     = (reg_idx_q == LastReg) ? StMemReq : StRegReq;
                reg_idx_d = reg_idx_q + NB_REG'(1);
                state_d   = StSend;
            end
            StMemReq: begin
                mem_rd     = 1'b1;
                mem_addr_d = mem_idx_q;
                state_d    = StMemWait;
            end
            StMemWait: begin
                if (mem_idx_q != LastMem) begin
                    mem_idx_d = mem_idx_q + NB_MEM_ADDR'(1);
                end
                if (dbg.mem_dirty) begin
                    shreg_d = NbSh'({8'(mem_idx_q), dbg.mem_data}) << (NbSh - NB_DATA - 8);
                    cnt_d   = NbCnt'(NB_DATA / 8 + 1);
                    ret_d   = mem_next;
                    state_d = StSend;
                end else begin
                    state_d = mem_next;
                end
            end
            StMark: begin
                shreg_d = NbSh'(8'hFF) << (NbSh - 8);
                cnt_d   = NbCnt'(1);
                ret_d   = StFin;
                state_d = StSend;
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read addresses show the live index only while requesting, then hold it.
    assign dbg.reg_addr = (state_q == StRegReq) ? reg_idx_q : reg_addr_q;
    assign dbg.mem_addr = (state_q == StMemReq) ? mem_idx_q : mem_addr_q;
    assign dbg.reg_rd   = reg_rd;
    assign dbg.mem_rd   = mem_rd;
    assign dbg.tx_data  = shreg_q[NbSh-1 -: 8];
    assign dbg.tx_start = tx_start;
    assign dbg.busy     = (state_q != StIdle);
    assign dbg.done     = done;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench: UART/register/memory models around the dump sequencer, comparing
// captured byte frames against frames built from the bench's own model arrays.
module tb_debug_dump_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_dump_sequencer_if #(
        .NB_DATA(32), .NB_REG(5), .NB_MEM_ADDR(7), .NB_PC(32)
    ) dbg ();

    debug_dump_sequencer #(
        .NB_DATA(32), .NB_REG(5), .NB_MEM_ADDR(7), .NB_PC(32)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .dbg    (dbg)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] regs_m  [32];
    logic [31:0] mem_m   [128];
    logic        dirty_m [128];

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [4:0] reg_addrs[$];
    int mem_rd_cnt;
    int done_cnt;
    int stab_err;
    int dly_min = 1;
    int dly_max = 3;
    bit spur_en = 1'b0;
    int uart_d;
    logic [7:0] uart_cap;

    // Synchronous debug read ports: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (dbg.reg_rd) dbg.reg_data <= regs_m[dbg.reg_addr];
        if (dbg.mem_rd) begin
            dbg.mem_data  <= mem_m[dbg.mem_addr];
            dbg.mem_dirty <= dirty_m[dbg.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (dbg.reg_rd) reg_addrs.push_back(dbg.reg_addr);
        if (dbg.mem_rd) mem_rd_cnt++;
        if (dbg.done) done_cnt++;
    end

    // UART model: capture on tx_start, answer tx_done after a delay; optional
    // spurious done ticks in SEND and while idle.
    initial begin
        dbg.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            dbg.tx_done = 1'b0;
            if (dbg.tx_start === 1'b1) begin
                uart_cap = dbg.tx_data;
                got.push_back(uart_cap);
                if (spur_en) dbg.tx_done = 1'b1;
                uart_d = $urandom_range(dly_max, dly_min);
                for (int i = 1; i < uart_d; i++) begin
                    @(negedge clk);
                    dbg.tx_done = 1'b0;
                    if (rst_n && (dbg.tx_data !== uart_cap || dbg.tx_start !== 1'b0))
                        stab_err++;
                end
                @(negedge clk);
                if (rst_n && dbg.tx_data !== uart_cap) stab_err++;
                dbg.tx_done = 1'b1;
            end else if (spur_en && !dbg.busy && $urandom_range(3, 0) == 0) begin
                dbg.tx_done = 1'b1;
            end
        end
    end

    task automatic build_exp(input logic [31:0] pc, input logic [31:0] cyc);
        exp_q.delete();
        for (int b = 3; b >= 0; b--) exp_q.push_back(pc[b*8 +: 8]);
        for (int b = 3; b >= 0; b--) exp_q.push_back(cyc[b*8 +: 8]);
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs_m[r][b*8 +: 8]);
        for (int a = 0; a < 128; a++) begin
            if (dirty_m[a]) begin
                exp_q.push_back(8'(a));
                for (int b = 3; b >= 0; b--) exp_q.push_back(mem_m[a][b*8 +: 8]);
            end
        end
        exp_q.push_back(8'hFF);
    endtask

    function automatic int first_diff();
        int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic start_frame(input logic [31:0] pc, input logic [31:0] cyc);
        @(negedge clk);
        got.delete();
        reg_addrs.delete();
        mem_rd_cnt = 0;
        done_cnt   = 0;
        stab_err   = 0;
        dbg.pc     = pc;
        dbg.cycles = cyc;
        dbg.start  = 1'b1;
        @(negedge clk);
        dbg.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (dbg.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        dbg.start = 1'b0;
        dbg.pc = '0;
        dbg.cycles = '0;
        repeat (3) @(negedge clk);
        checks++; if (dbg.tx_data !== 8'h00) begin failures++;
            $display("FAIL reset_tx_data: got %0h want 0", dbg.tx_data); end
        checks++; if (dbg.tx_start !== 1'b0) begin failures++;
            $display("FAIL reset_tx_start: got %0b want 0", dbg.tx_start); end
        checks++; if (dbg.reg_addr !== 5'd0 || dbg.reg_rd !== 1'b0) begin failures++;
            $display("FAIL reset_reg_port: got addr %0h rd %0b want 0 0", dbg.reg_addr, dbg.reg_rd); end
        checks++; if (dbg.mem_addr !== 7'd0 || dbg.mem_rd !== 1'b0) begin failures++;
            $display("FAIL reset_mem_port: got addr %0h rd %0b want 0 0", dbg.mem_addr, dbg.mem_rd); end
        checks++; if (dbg.busy !== 1'b0 || dbg.done !== 1'b0) begin failures++;
            $display("FAIL reset_busy_done: got %0b %0b want 0 0", dbg.busy, dbg.done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        bit ok;
        int bad_addr = -1;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'(i);
        for (int a = 0; a < 128; a++) begin mem_m[a] = 32'h0; dirty_m[a] = 1'b0; end
        build_exp(32'h0000_0003, 32'h0000_0004);
        start_frame(32'h0000_0003, 32'h0000_0004);
        checks++; if (dbg.busy !== 1'b1 || dbg.tx_start !== 1'b1) begin failures++;
            $display("FAIL basic_start_latency: got busy %0b tx_start %0b want 1 1",
                     dbg.busy, dbg.tx_start); end
        checks++; if (dbg.tx_data !== 8'h00) begin failures++;
            $display("FAIL basic_first_byte: got %0h want 0", dbg.tx_data); end
        wait_done(5000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL basic_timeout: got no done want done within 5000 cycles"); end
        checks++; if (dbg.busy !== 1'b1) begin failures++;
            $display("FAIL basic_busy_at_fin: got %0b want 1", dbg.busy); end
        @(negedge clk);
        checks++; if (dbg.busy !== 1'b0 || dbg.done !== 1'b0) begin failures++;
            $display("FAIL basic_busy_after: got busy %0b done %0b want 0 0", dbg.busy, dbg.done); end
        repeat (3) @(negedge clk);
        checks++; if (got.size() != 137) begin failures++;
            $display("FAIL basic_length: got %0d want 137", got.size()); end
        checks++; if (first_diff() != -1) begin failures++;
            $display("FAIL basic_bytes: first difference at byte %0d", first_diff()); end
        checks++; if (done_cnt != 1) begin failures++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        for (int i = 0; i < reg_addrs.size(); i++)
            if (bad_addr < 0 && reg_addrs[i] !== 5'(i)) bad_addr = i;
        checks++; if (reg_addrs.size() != 32 || bad_addr != -1) begin failures++;
            $display("FAIL basic_reg_reads: got %0d reads, first bad %0d want 32 reads 0..31",
                     reg_addrs.size(), bad_addr); end
        checks++; if (mem_rd_cnt != 128) begin failures++;
            $display("FAIL basic_mem_reads: got %0d want 128", mem_rd_cnt); end
    endtask

    task automatic test_dirty_mem();
        bit ok;
        mem_m[2] = 32'hDEAD_BEEF;   dirty_m[2] = 1'b1;
        mem_m[5] = 32'h5555_5555;   dirty_m[5] = 1'b0;
        mem_m[127] = 32'h0102_0304; dirty_m[127] = 1'b1;
        build_exp(32'h1234_5678, 32'h9ABC_DEF0);
        start_frame(32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(5000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL dirty_timeout: got no done want done within 5000 cycles"); end
        repeat (4) @(negedge clk);
        checks++; if (got.size() != 147) begin failures++;
            $display("FAIL dirty_length: got %0d want 147", got.size()); end
        checks++; if (first_diff() != -1) begin failures++;
            $display("FAIL dirty_bytes: first difference at byte %0d", first_diff()); end
        checks++; if (got.size() == 147 && (got[136] !== 8'h02 || got[141] !== 8'h7F)) begin
            failures++;
            $display("FAIL dirty_addr_bytes: got %0h %0h want 02 7f", got[136], got[141]); end
        checks++; if (mem_rd_cnt != 128) begin failures++;
            $display("FAIL dirty_mem_reads: got %0d want 128", mem_rd_cnt); end
        dirty_m[2] = 1'b0;
        dirty_m[127] = 1'b0;
    endtask

    task automatic test_tx_delay_spurious();
        bit ok;
        dly_min = 1;
        dly_max = 500;
        spur_en = 1'b1;
        repeat (5) @(negedge clk);
        build_exp(32'hA5A5_0001, 32'h0000_1234);
        start_frame(32'hA5A5_0001, 32'h0000_1234);
        wait_done(60000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL delay_timeout: got no done want done within 60000 cycles"); end
        repeat (4) @(negedge clk);
        checks++; if (got.size() != 137) begin failures++;
            $display("FAIL delay_length: got %0d want 137", got.size()); end
        checks++; if (first_diff() != -1) begin failures++;
            $display("FAIL delay_bytes: first difference at byte %0d", first_diff()); end
        checks++; if (stab_err != 0) begin failures++;
            $display("FAIL delay_tx_stable: got %0d unstable cycles want 0", stab_err); end
        checks++; if (done_cnt != 1) begin failures++;
            $display("FAIL delay_done_count: got %0d want 1", done_cnt); end
        spur_en = 1'b0;
        dly_max = 3;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_ignored_start();
        bit ok;
        int c;
        build_exp(32'h1122_3344, 32'h5566_7788);
        start_frame(32'h1122_3344, 32'h5566_7788);
        for (c = 0; c < 2000 && got.size() < 20; c++) @(negedge clk);
        dbg.pc     = 32'hFFFF_FFFF;
        dbg.cycles = 32'hFFFF_FFFF;
        dbg.start  = 1'b1;
        @(negedge clk);
        dbg.start  = 1'b0;
        wait_done(5000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL ignore_timeout: got no done want done within 5000 cycles"); end
        repeat (4) @(negedge clk);
        checks++; if (got.size() != 137 || first_diff() != -1) begin failures++;
            $display("FAIL ignore_frame: got %0d bytes, first diff %0d want 137 matching",
                     got.size(), first_diff()); end
        checks++; if (done_cnt != 1 || dbg.busy !== 1'b0) begin failures++;
            $display("FAIL ignore_done: got done %0d busy %0b want 1 0", done_cnt, dbg.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c;
        start_frame(32'hCAFE_0000, 32'h0000_00AA);
        for (c = 0; c < 2000 && got.size() < 50; c++) @(negedge clk);
        checks++; if (got.size() < 50) begin failures++;
            $display("FAIL midrst_progress: got %0d bytes want 50", got.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dbg.tx_start !== 1'b0 || dbg.tx_data !== 8'h00 || dbg.busy !== 1'b0)
        begin failures++;
            $display("FAIL midrst_tx_outputs: got start %0b data %0h busy %0b want 0 0 0",
                     dbg.tx_start, dbg.tx_data, dbg.busy); end
        checks++; if (dbg.reg_rd !== 1'b0 || dbg.mem_rd !== 1'b0 || dbg.reg_addr !== 5'd0 ||
                      dbg.mem_addr !== 7'd0 || dbg.done !== 1'b0) begin failures++;
            $display("FAIL midrst_rd_outputs: got %0b %0b %0h %0h %0b want all 0",
                     dbg.reg_rd, dbg.mem_rd, dbg.reg_addr, dbg.mem_addr, dbg.done); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != 0) begin failures++;
            $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
        build_exp(32'h0BAD_F00D, 32'h0000_0007);
        start_frame(32'h0BAD_F00D, 32'h0000_0007);
        wait_done(5000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL midrst_timeout: got no done want done within 5000 cycles"); end
        repeat (4) @(negedge clk);
        checks++; if (got.size() != 137 || first_diff() != -1) begin failures++;
            $display("FAIL midrst_frame: got %0d bytes, first diff %0d want 137 matching",
                     got.size(), first_diff()); end
        checks++; if (done_cnt != 1) begin failures++;
            $display("FAIL midrst_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_dirty_mem();
        test_tx_delay_spurious();
        test_ignored_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
